// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the millisecond timeout scheduler.
// Optional auto-reload channels are enabled with `define TIMER_SCHED_RELOAD_EN.
package timer_sched_pkg;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_t;

  // Width needed to hold a timeout of 0..max_ms.
  function automatic int ms_width(input int max_ms);
    return $clog2(max_ms + 1);
  endfunction

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Requester-side bundle of the timeout scheduler (master = requesters, slave = scheduler).
// The periodic vector exists only when TIMER_SCHED_RELOAD_EN is defined.
interface timer_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int MS_W   = 11
);
  logic                     enable;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*MS_W-1:0]   dur;
  logic [NUM_CH-1:0]        cancel;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        expired;
`ifdef TIMER_SCHED_RELOAD_EN
  logic [NUM_CH-1:0]        periodic;

  modport master (output enable, req, dur, cancel, periodic, input grant, busy, expired);
  modport slave  (input enable, req, dur, cancel, periodic, output grant, busy, expired);
`else
  modport master (output enable, req, dur, cancel, input grant, busy, expired);
  modport slave  (input enable, req, dur, cancel, output grant, busy, expired);
`endif
endinterface

// File: rtl/timer_sched_channel.sv
// One timeout channel: IDLE/RUN state plus a millisecond countdown advanced by the shared tick.
// With TIMER_SCHED_RELOAD_EN a periodic channel reloads its duration instead of stopping.
module timer_sched_channel
  import timer_sched_pkg::*;
#(
  parameter int MS_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            start,
  input  logic [MS_W-1:0] dur,
  input  logic            cancel,
`ifdef TIMER_SCHED_RELOAD_EN
  input  logic            periodic,
`endif
  output logic            busy,
  output logic            expired
);

  ch_state_t       state_q, state_d;
  logic [MS_W-1:0] rem_q, rem_d;
  logic            expired_q, expired_d;
  logic            auto_reload;
  logic [MS_W-1:0] start_len, reload_len;

`ifdef TIMER_SCHED_RELOAD_EN
  logic            periodic_q;
  logic [MS_W-1:0] reload_q;

  // A periodic zero-length timeout would expire every cycle; run it as 1 ms instead.
  assign start_len   = (periodic && dur == '0) ? MS_W'(1) : dur;
  assign auto_reload = periodic_q;
  assign reload_len  = reload_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      periodic_q <= 1'b0;
      reload_q   <= '0;
    end else if (start && state_q == CH_IDLE) begin
      periodic_q <= periodic;
      reload_q   <= start_len;
    end
  end
`else
  assign start_len   = dur;
  assign auto_reload = 1'b0;
  assign reload_len  = '0;
`endif

  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
    state_d   = state_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (start) begin
          if (start_len == '0) begin
            expired_d = 1'b1;
          end else begin
            state_d = CH_RUN;
            rem_d   = start_len;
          end
        end
      end
      CH_RUN: begin
        if (cancel) begin
          state_d = CH_IDLE;
          rem_d   = '0;
        end else if (tick) begin
          if (rem_q > MS_W'(1)) begin
            rem_d = rem_q - MS_W'(1);
          end else begin
            expired_d = 1'b1;
            if (auto_reload) begin
              rem_d = reload_len;
            end else begin
              state_d = CH_IDLE;
              rem_d   = '0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset) begin
      state_q   <= CH_IDLE;
      rem_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
    end
  end

  assign busy    = (state_q == CH_RUN);
  assign expired = expired_q;

endmodule

// File: rtl/timer_scheduler.sv
// Shared millisecond prescaler plus a round-robin start arbiter over NUM_CH timeout channels.
// Define TIMER_SCHED_RELOAD_EN to add per-channel periodic (auto-reload) timeouts.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLKS_PER_MS = 50000,
  parameter int MAX_MS      = 2000
) (
  input  logic               clk,
  input  logic               reset,
  timer_scheduler_if.slave   bus
);

  localparam int MS_W  = ms_width(MAX_MS);
  localparam int PS_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int PTR_W = $clog2(NUM_CH);

  logic [PS_W-1:0]   ps_q;
  logic              tick;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  sel_idx;
  logic              found;
  logic [NUM_CH-1:0] elig, start_v, grant_q, busy_v, expired_v;
  int                idx;

  // Free-running: grants never restart it, so a timeout's first ms may be partial.
  assign tick = bus.enable && (ps_q == PS_W'(CLKS_PER_MS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      ps_q <= '0;
    end else if (bus.enable) begin
      ps_q <= tick ? '0 : ps_q + PS_W'(1);
    end
  end

  assign elig = bus.req & ~busy_v;

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int o = 0; o < NUM_CH; o++) begin
      idx = int'(ptr_q) + o;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        sel_idx = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      grant_q <= start_v;
      if (found) ptr_q <= PTR_W'(rr_next(int'(sel_idx), NUM_CH));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [MS_W-1:0] dur_raw, dur_clamped;

    assign start_v[i]  = found && (sel_idx == PTR_W'(i));
    assign dur_raw     = bus.dur[i*MS_W +: MS_W];
    assign dur_clamped = (dur_raw > MS_W'(MAX_MS)) ? MS_W'(MAX_MS) : dur_raw;

    timer_sched_channel #(.MS_W(MS_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .start    (start_v[i]),
      .dur      (dur_clamped),
      .cancel   (bus.cancel[i]),
`ifdef TIMER_SCHED_RELOAD_EN
      .periodic (bus.periodic[i]),
`endif
      .busy     (busy_v[i]),
      .expired  (expired_v[i])
    );
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_v;
  assign bus.expired = expired_v;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed and randomized bench for timer_scheduler against a per-cycle reference model.
// Covers TIMER_SCHED_RELOAD_EN behaviour when that macro is defined.
module tb_timer_scheduler;
  import timer_sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CLKS   = 4;
  localparam int MAX_MS = 20;
  localparam int MS_W   = ms_width(MAX_MS);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  timer_scheduler_if #(.NUM_CH(NUM_CH), .MS_W(MS_W)) bus ();

  timer_scheduler #(.NUM_CH(NUM_CH), .CLKS_PER_MS(CLKS), .MAX_MS(MAX_MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining ms per channel (0 = idle), prescaler phase, rr pointer.
  int m_ptr, m_ps;
  int m_rem[NUM_CH];
  int m_reload[NUM_CH];
  bit m_per[NUM_CH];
  logic [NUM_CH-1:0] m_grant, m_busy, m_exp;

  task automatic set_dur(input int ch, input int v);
    bus.dur[ch*MS_W +: MS_W] = MS_W'(v);
  endtask

  function automatic int dur_of(input int ch);
    logic [MS_W-1:0] d;
    d = bus.dur[ch*MS_W +: MS_W];
    return int'(d);
  endfunction

  // Advance model and DUT by one clock, then compare all outputs.
  task automatic step();
    logic [NUM_CH-1:0] g, e;
    bit tick;
    int win, d;
    g = '0;
    e = '0;
    win = -1;
    if (!reset) begin
      m_ptr = 0;
      m_ps  = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_rem[i] = 0; m_per[i] = 0; m_reload[i] = 0;
      end
    end else begin
      tick = bus.enable && (m_ps == CLKS - 1);
      for (int o = 0; o < NUM_CH; o++) begin
        int c;
        c = (m_ptr + o) % NUM_CH;
        if (win < 0 && bus.req[c] && m_rem[c] == 0) win = c;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_rem[i] > 0) begin
          if (bus.cancel[i]) m_rem[i] = 0;
          else if (tick) begin
            if (m_rem[i] == 1) begin
              e[i] = 1'b1;
              m_rem[i] = m_per[i] ? m_reload[i] : 0;
            end else begin
              m_rem[i] = m_rem[i] - 1;
            end
          end
        end
      end
      if (win >= 0) begin
        g[win] = 1'b1;
        m_ptr = (win + 1) % NUM_CH;
        d = dur_of(win);
        if (d > MAX_MS) d = MAX_MS;
        m_per[win] = 1'b0;
`ifdef TIMER_SCHED_RELOAD_EN
        m_per[win] = bus.periodic[win];
        if (m_per[win] && d == 0) d = 1;
`endif
        m_reload[win] = d;
        if (d == 0) e[win] = 1'b1;
        else m_rem[win] = d;
      end
      if (bus.enable) m_ps = (m_ps + 1) % CLKS;
    end
    m_grant = g;
    m_exp   = e;
    for (int i = 0; i < NUM_CH; i++) m_busy[i] = (m_rem[i] > 0);
    @(posedge clk);
    #1;
    check("grant", bus.grant, m_grant);
    check("busy", bus.busy, m_busy);
    check("expired", bus.expired, m_exp);
    bus.req = bus.req & ~m_grant;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int len, npulse, last, found;
    bus.enable = 1'b1;
    bus.req    = '0;
    bus.cancel = '0;
    bus.dur    = '0;
`ifdef TIMER_SCHED_RELOAD_EN
    bus.periodic = '0;
`endif

    // Reset state
    reset = 1'b0;
    run(2);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b1;

    // 1: single 3 ms timeout on ch1
    set_dur(1, 3);
    bus.req[1] = 1'b1;
    step();
    check("t1_grant", bus.grant, 4'b0010);
    len = 1; npulse = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.busy[1]) len++;
      if (bus.expired[1]) npulse++;
    end
    check("t1_busy_len_in_9_12", (len >= 9 && len <= 12), 1);
    check("t1_pulses", npulse, 1);
    check("t1_idle_after", bus.busy, 0);

    // 2: round-robin order from pointer 0, then from pointer 1
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_dur(i, 2);
    bus.req = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      step();
      check($sformatf("t2_order_a%0d", k), bus.grant, 1 << k);
    end
    run(16);
    set_dur(0, 0);
    bus.req = 4'b0001;
    step();
    check("t2_ch0_grant", bus.grant, 4'b0001);
    set_dur(0, 2);
    bus.req = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      step();
      check($sformatf("t2_order_b%0d", k), bus.grant, 1 << ((k + 1) % NUM_CH));
    end
    run(16);

    // 3: cancel on the same cycle as the final tick
    set_dur(2, 3);
    bus.req[2] = 1'b1;
    step();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (m_rem[2] == 1 && m_ps == CLKS - 1) found = 1;
      else step();
    end
    check("t3_final_tick_reached", found, 1);
    bus.cancel[2] = 1'b1;
    step();
    bus.cancel[2] = 1'b0;
    check("t3_no_expired", bus.expired[2], 0);
    check("t3_busy_fell", bus.busy[2], 0);

    // 4: zero duration and clamped duration
    set_dur(3, 0);
    bus.req[3] = 1'b1;
    step();
    check("t4_zero_grant", bus.grant, 4'b1000);
    check("t4_zero_expired", bus.expired, 4'b1000);
    check("t4_zero_busy", bus.busy[3], 0);
    step();
    check("t4_zero_busy_after", bus.busy[3], 0);
    set_dur(3, 31);
    bus.req[3] = 1'b1;
    step();
    len = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.busy[3]) len++;
    end
    check("t4_clamp_len_in_77_80", (len >= 77 && len <= 80), 1);

    // 5: enable freeze delays expiry by exactly the frozen cycles; reset mid-count
    set_dur(0, 5);
    bus.req[0] = 1'b1;
    step();
    len = 1;
    for (int k = 0; k < 5; k++) begin step(); if (bus.busy[0]) len++; end
    bus.enable = 1'b0;
    for (int k = 0; k < 50; k++) begin step(); if (bus.busy[0]) len++; end
    check("t5_frozen_busy", bus.busy[0], 1);
    bus.enable = 1'b1;
    for (int k = 0; k < 40; k++) begin step(); if (bus.busy[0]) len++; end
    check("t5_frozen_len_in_67_70", (len >= 67 && len <= 70), 1);
    set_dur(1, 5);
    bus.req[1] = 1'b1;
    step();
    run(3);
    reset = 1'b0;
    step();
    check("t5_rst_grant", bus.grant, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_expired", bus.expired, 0);
    reset = 1'b1;
    npulse = 0;
    for (int k = 0; k < 30; k++) begin step(); if (bus.expired != 0) npulse++; end
    check("t5_no_expired_after_rst", npulse, 0);

`ifdef TIMER_SCHED_RELOAD_EN
    // 6: periodic channel every 8 cycles until cancelled
    do_reset();
    bus.periodic[0] = 1'b1;
    set_dur(0, 2);
    bus.req[0] = 1'b1;
    step();
    npulse = 0; last = -1; len = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!bus.busy[0]) len++;
      if (bus.expired[0]) begin
        if (last >= 0) check("t6_period", k - last, 8);
        last = k;
        npulse++;
      end
    end
    check("t6_pulses_ge4", (npulse >= 4), 1);
    check("t6_busy_dropouts", len, 0);
    bus.cancel[0] = 1'b1;
    step();
    bus.cancel[0] = 1'b0;
    bus.periodic[0] = 1'b0;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin step(); if (bus.expired[0]) npulse++; end
    check("t6_stopped", npulse, 0);
    check("t6_idle", bus.busy[0], 0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
          set_dur(i, int'($urandom_range(0, 31)));
        end
        bus.cancel[i] = ($urandom_range(0, 29) == 0);
`ifdef TIMER_SCHED_RELOAD_EN
        bus.periodic[i] = ($urandom_range(0, 4) == 0);
`endif
      end
      bus.enable = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
Shares one millisecond prescaler among NUM_CH independent timeout channels. Each requester asks for a timeout of N ms through a req/grant handshake. A round-robin arbiter starts at most one channel per cycle. Each channel counts down on the shared ms tick and pulses expired when done. It sits between game/control FSMs and the shared time base, replacing per-FSM millisecond timer instances.

Parameters:
NUM_CH, 4, number of requester channels (2..16)
CLKS_PER_MS, 50000, clk cycles per millisecond tick
MAX_MS, 2000, largest programmable timeout; MS_W = $clog2(MAX_MS+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  high: prescaler and countdowns advance; low: both frozen, arbitration still runs
req  in  NUM_CH  per-channel start request, level, held until grant
dur  in  NUM_CH*MS_W  per-channel duration in ms, channel i at [i*MS_W +: MS_W], sampled on grant
cancel  in  NUM_CH  per-channel abort, level
grant  out  NUM_CH  one-hot, one-cycle pulse acknowledging req
busy  out  NUM_CH  channel counting
expired  out  NUM_CH  one-cycle pulse per channel at timeout

Behaviour:
- Reset (reset==0 at posedge): prescaler=0, rr pointer=0, all channels IDLE, remaining=0; grant, busy, expired all 0. Applies mid-count; no expired pulse is generated.
- Prescaler: counts 0..CLKS_PER_MS-1 while enable=1, wraps to 0. tick = enable && count==CLKS_PER_MS-1, high for one cycle. Free-running, never restarted by grants. A timeout of D ms therefore lasts between (D-1)*CLKS_PER_MS+1 and D*CLKS_PER_MS cycles after grant.
- Eligibility: req[i] && !busy[i]. req from a busy channel waits; it is not granted until the channel returns to IDLE.
- Arbiter: round-robin. Search starts at pointer and takes the first eligible index modulo NUM_CH. Registered: grant[k] asserts the cycle after eligibility is seen. On the same edge busy[k] rises and the pointer moves to k+1 (wrapping). At most one grant per cycle. With no eligible channel, the pointer holds.
- dur sampled at the grant edge. If dur > MAX_MS, it is clamped to MAX_MS. If dur==0: busy stays 0 and expired[k] pulses in the same cycle as grant[k].
- Channel FSM: IDLE -> RUN on grant (dur>0). RUN with tick and remaining>1: remaining decrements. RUN with tick and remaining==1: expired pulses, busy falls, state returns to IDLE, all on the same edge. RUN with cancel: returns to IDLE, no expired pulse. cancel has priority over tick on the same cycle. cancel in IDLE is ignored.
- Requester must drop req the cycle it sees grant. If req is still high after busy falls, it is re-granted (the normal restart path).
- enable low: ticks are suppressed, so remaining and the prescaler hold. Grants and cancels still function.

Optional Feature:
TIMER_SCHED_RELOAD_EN
- Defined: adds input periodic [NUM_CH], sampled at grant. A periodic channel at expiry pulses expired, reloads the latched (clamped) dur, and stays busy (RUN). It stops only on cancel or reset. dur==0 with periodic is treated as dur=1.
- Undefined: port absent; all channels are one-shot as described above.

Decomposition:
- Package timer_sched_pkg: channel state enum (CH_IDLE, CH_RUN), MS_W computation function, rr next-index function.
- Sub-module: timer_sched_channel (per-channel FSM + remaining counter, inputs tick/start/dur/cancel), instantiated NUM_CH times via generate.
- Prescaler and arbiter stay in the top.

Test Plan:
(All with CLKS_PER_MS=4, MAX_MS=20, NUM_CH=4.)
1. req[1], dur=3, enable=1 -> grant[1] next cycle; busy[1] for 9..12 cycles; single expired[1] pulse; busy[1]=0 after.
2. req=4'b1111 together, all dur=2 -> grants in order ch0,1,2,3 on consecutive cycles. A second round of requests, after the pointer has moved to 1 following a grant to ch0, starts at ch1.
3. Channel 2 running, cancel[2] asserted on the same cycle as its final tick -> no expired[2]; busy[2] falls.
4. dur=0 on ch3 -> grant[3] and expired[3] pulse in the same cycle; busy[3] never 1. dur=31 -> behaves as 20 ms (77..80 cycles).
5. enable held low for 50 cycles mid-count -> remaining frozen; expiry delayed by exactly 50 cycles. reset pulled low mid-count -> all outputs 0 next cycle, no expired.
6. TIMER_SCHED_RELOAD_EN defined, periodic[0]=1, dur=2 -> expired[0] every 8 cycles, busy stays 1. After cancel: no further pulses.
